// File: rtl/weights_update_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | weights_update_writer: writable weight store with SGD update engine    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module weights_update_writer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 6,
  parameter int ADDR_W   = 4,
  parameter int LR_SHIFT = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] wt_out,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_grad,
  output logic              done,
  output logic              err,
  output logic              sat,
  output logic [CNT_W-1:0]  upd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  weights_q [DEPTH];
  logic [DATA_W-1:0]  weights_d [DEPTH];
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  grad_q, grad_d;
  logic [DATA_W-1:0]  res_q, res_d;
  logic               res_sat_q, res_sat_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   upd_count_q, upd_count_d;

  logic [DATA_W-1:0]        cur_w;
  logic signed [DATA_W-1:0] delta;
  logic signed [DATA_W:0]   diff;
  logic                     diff_ovf;
  logic                     addr_ok;
  logic                     ld_addr_ok;

  assign addr_ok    = int'(addr_q) < DEPTH;
  assign ld_addr_ok = int'(ld_addr) < DEPTH;

  always_comb begin
    wt_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(r_addr) == i) wt_out = weights_q[i];
    end
  end

  always_comb begin
    cur_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(addr_q) == i) cur_w = weights_q[i];
    end
  end

  // One extra bit of headroom makes the overflow test a simple sign-bit compare.
  assign delta    = $signed(grad_q) >>> LR_SHIFT;
  assign diff     = $signed({cur_w[DATA_W-1], cur_w}) - $signed({delta[DATA_W-1], delta});
  assign diff_ovf = diff[DATA_W] != diff[DATA_W-1];

  assign upd_ready = (state_q == IDLE) && !ld_valid;

  always_comb begin
    state_d     = state_q;
    weights_d   = weights_q;
    addr_d      = addr_q;
    grad_d      = grad_q;
    res_d       = res_q;
    res_sat_d   = res_sat_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sat_d       = 1'b0;
    upd_count_d = upd_count_q;

    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          done_d = 1'b1;
          err_d  = !ld_addr_ok;
          for (int i = 0; i < DEPTH; i++) begin
            if (int'(ld_addr) == i) weights_d[i] = ld_data;
          end
        end else if (upd_valid) begin
          addr_d  = upd_addr;
          grad_d  = upd_grad;
          state_d = CALC;
        end
      end
      CALC: begin
        if (diff_ovf) begin
          res_d = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
          res_d = diff[DATA_W-1:0];
        end
        res_sat_d = diff_ovf && addr_ok;
        state_d   = WRITE;
      end
      WRITE: begin
        done_d  = 1'b1;
        err_d   = !addr_ok;
        sat_d   = res_sat_q;
        state_d = IDLE;
        if (addr_ok) begin
          upd_count_d = upd_count_q + CNT_W'(1);
          for (int i = 0; i < DEPTH; i++) begin
            if (int'(addr_q) == i) weights_d[i] = res_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) weights_q[i] <= '0;
      addr_q      <= '0;
      grad_q      <= '0;
      res_q       <= '0;
      res_sat_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
      upd_count_q <= '0;
    end else begin
      state_q     <= state_d;
      weights_q   <= weights_d;
      addr_q      <= addr_d;
      grad_q      <= grad_d;
      res_q       <= res_d;
      res_sat_q   <= res_sat_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
      upd_count_q <= upd_count_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign sat       = sat_q;
  assign upd_count = upd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_weights_update_writer.sv
`default_nettype none
// Directed bench for weights_update_writer with a transaction-level reference model.
module tb_weights_update_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  r_addr = '0;
  logic [15:0] wt_out;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [3:0]  upd_addr = '0;
  logic [15:0] upd_grad = '0;
  logic        done, err, sat;
  logic [7:0]  upd_count;

  int checks = 0;
  int failures = 0;

  weights_update_writer #(
    .DATA_W(16), .DEPTH(6), .ADDR_W(4), .LR_SHIFT(4), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .r_addr(r_addr), .wt_out(wt_out),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
    .upd_grad(upd_grad), .done(done), .err(err), .sat(sat), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: weights as a plain array, one outstanding update at a time.
  logic [15:0] mw [16];
  int          ec, busy_until, m_count;
  logic        pend, pend_err, pend_sat;
  int          pend_due;
  logic [3:0]  pend_addr;
  logic [15:0] pend_res;
  logic        e_done, e_err, e_sat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mw[i] = '0;
      ec = 0; busy_until = 0; m_count = 0; pend = 0;
      e_done = 0; e_err = 0; e_sat = 0;
    end else begin
      e_done = 0; e_err = 0; e_sat = 0;
      if (pend && ec == pend_due) begin
        pend = 0;
        e_done = 1; e_err = pend_err; e_sat = pend_sat;
        if (!pend_err) begin
          mw[pend_addr] = pend_res;
          m_count = (m_count + 1) % 256;
        end
      end
      if (ec >= busy_until) begin
        if (ld_valid) begin
          e_done = 1;
          e_err  = (ld_addr >= 6);
          if (ld_addr < 6) mw[ld_addr] = ld_data;
        end else if (upd_valid) begin
          int wi, gi, r;
          logic s;
          wi = int'($signed(mw[upd_addr]));
          gi = int'($signed(upd_grad));
          r  = wi - (gi >>> 4);
          s  = 0;
          if (r > 32767) begin r = 32767; s = 1; end
          if (r < -32768) begin r = -32768; s = 1; end
          pend      = 1;
          pend_addr = upd_addr;
          pend_res  = r[15:0];
          pend_err  = (upd_addr >= 6);
          pend_sat  = s && (upd_addr < 6);
          pend_due  = ec + 2;
          busy_until = ec + 3;
        end
      end
      ec++;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("done", done, e_done);
      check("err", err, e_err);
      check("sat", sat, e_sat);
      check("upd_ready", upd_ready, (ec >= busy_until) && !ld_valid);
      check("upd_count", upd_count, m_count[7:0]);
      check("wt_out", wt_out, mw[r_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    #1;
  endtask

  // Returns in the cycle where done for this update is expected high.
  task automatic do_upd(input logic [3:0] a, input logic [15:0] g);
    int tries;
    upd_addr = a; upd_grad = g; upd_valid = 1'b1;
    #1;
    tries = 0;
    while (!upd_ready && tries < 20) begin
      step();
      tries++;
    end
    if (!upd_ready) check("upd_accept_timeout", 32'd0, 32'd1);
    step();
    upd_valid = 1'b0;
    step();
    step();
    #1;
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [15:0] exp);
    r_addr = a;
    #1;
    check(name, wt_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // T1 reset state
    for (int a = 0; a < 8; a++) peek("t1_wt", 4'(a), 16'h0000);
    check("t1_ready", upd_ready, 1);
    check("t1_done", done, 0);
    check("t1_count", upd_count, 0);

    // T2 load + update
    do_load(4'd2, 16'h0100);
    check("t2_ld_done", done, 1);
    do_upd(4'd2, 16'h0040);
    check("t2_done", done, 1);
    check("t2_sat", sat, 0);
    check("t2_count", upd_count, 1);
    peek("t2_w2", 4'd2, 16'h00FC);

    // T3 saturation both directions
    do_load(4'd0, 16'h7FF0);
    do_upd(4'd0, 16'h8000);
    check("t3_sat_hi", sat, 1);
    peek("t3_w0", 4'd0, 16'h7FFF);
    do_load(4'd1, 16'h8010);
    do_upd(4'd1, 16'h7FF0);
    check("t3_sat_lo", sat, 1);
    peek("t3_w1", 4'd1, 16'h8000);
    check("t3_count", upd_count, 3);

    // T4 bad addresses
    do_upd(4'd7, 16'h0100);
    check("t4_upd_done", done, 1);
    check("t4_upd_err", err, 1);
    check("t4_upd_sat", sat, 0);
    check("t4_count", upd_count, 3);
    peek("t4_w0", 4'd0, 16'h7FFF);
    do_load(4'd9, 16'h1111);
    check("t4_ld_err", err, 1);

    // T5 contention: load wins, held update follows, requests during CALC/WRITE ignored
    ld_addr = 4'd5; ld_data = 16'h1234; ld_valid = 1'b1;
    upd_addr = 4'd5; upd_grad = 16'h0100; upd_valid = 1'b1;
    #1;
    check("t5_ready_blocked", upd_ready, 0);
    step();
    ld_valid = 1'b0;
    #1;
    check("t5_ready_free", upd_ready, 1);
    step();
    ld_addr = 4'd1; ld_data = 16'h7777; ld_valid = 1'b1;
    #1;
    check("t5_busy_calc", upd_ready, 0);
    step();
    #1;
    check("t5_busy_write", upd_ready, 0);
    step();
    ld_valid = 1'b0; upd_valid = 1'b0;
    #1;
    check("t5_done", done, 1);
    peek("t5_w5", 4'd5, 16'h1224);
    peek("t5_w1", 4'd1, 16'h8000);
    check("t5_count", upd_count, 4);

    // T6 reset during CALC
    do_load(4'd3, 16'h0500);
    upd_addr = 4'd3; upd_grad = 16'h0100; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    #2 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    peek("t6_w3", 4'd3, 16'h0000);
    check("t6_ready", upd_ready, 1);
    check("t6_count", upd_count, 0);
    repeat (3) begin
      step();
      check("t6_no_done", done, 0);
    end

    // Counter wrap: each update increments w[4] by one
    for (int i = 0; i < 255; i++) do_upd(4'd4, 16'hFFF0);
    check("wrap_255", upd_count, 255);
    do_upd(4'd4, 16'hFFF0);
    check("wrap_0", upd_count, 0);
    peek("wrap_w4", 4'd4, 16'h0100);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
